obi_sram_bridge: RTL and testbench
==================================

# obi_sram_bridge

Fabric user-design bus target sitting directly downstream of the CPU peripheral interface. It consumes the REQ/WE/BE/ADDR/WDATA request bus from `peripheral_wrapper` and returns GNT/RVALID/RDATA. Requests are served from an `IHP_SRAM_1024x32_wrapper` instance or from a small control/status register bank. An FSM sweeps the SRAM with zeros on software request, and the bus is stalled while the sweep runs.

## Interface
Parameters:
- `DEPTH`, default 1024: SRAM words; the clear sweep covers 0..DEPTH-1.
- `REG_BASE`, default 12'h001: ADDR[23:12] value that selects the register bank.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  clock.
  - `rst`  in  1  synchronous active-high reset.
- Bus request, from `peripheral_wrapper`:
  - `req`  in  1  bus request.
  - `we`  in  1  1 = write.
  - `be`  in  4  byte enables.
  - `addr`  in  24  byte address.
  - `wdata`  in  32  write data.
- Bus response, to `peripheral_wrapper`:
  - `gnt`  out  1  request accepted this cycle.
  - `rvalid`  out  1  response valid.
  - `rdata`  out  32  read data.
- SRAM side, to `IHP_SRAM_1024x32_wrapper`:
  - `sram_addr`  out  10  word address.
  - `sram_bm`  out  32  bit mask.
  - `sram_din`  out  32  write data.
  - `sram_wen`  out  1  write enable.
  - `sram_men`  out  1  macro enable.
  - `sram_ren`  out  1  read enable.
  - `sram_dout`  in  32  read data, valid the cycle after a read strobe.

## Operation
- Address decode on granted requests:
  - ADDR[23:12]==0: SRAM, word address ADDR[11:2].
  - ADDR[23:12]==REG_BASE: register bank, selected by ADDR[3:2].
  - Anything else: unmapped.
- FSM has two states, IDLE and CLEAR.
- IDLE:
  - `gnt` = `req`, combinational; any number of back-to-back requests are accepted.
- SRAM access (IDLE, granted):
  - `sram_men`=1; `sram_wen`=`we`; `sram_ren`=~`we`; `sram_din`=`wdata`.
  - `sram_bm[8i+7:8i]` = {8{`be[i]`}}.
  - With no grant, all SRAM strobes are 0.
- Registers, all 32 bits:
  - 0 CTRL:
    - Write with `be[0]` and `wdata[0]`=1 starts CLEAR.
    - Read returns {31'b0, busy}; busy always reads 0, because reads cannot be granted during CLEAR.
  - 1 SCRATCH: read/write, byte-wise per `be`.
  - 2 RD_COUNT: count of granted SRAM reads; any write clears it to 0.
  - 3 WR_COUNT: count of granted SRAM writes; any write clears it to 0.
  - Both counters wrap at 2^32.
- Unmapped accesses: writes are ignored; reads return 32'hBADC0DE0.
- CLEAR:
  - `gnt`=0.
  - Each cycle: `sram_men`=`sram_wen`=1, `sram_ren`=0, `sram_bm`=all ones, `sram_din`=0, `sram_addr`=sweep counter.
  - Counter runs 0..DEPTH-1, one word per cycle; after word DEPTH-1 the FSM returns to IDLE.
  - Counters are not incremented by the sweep.
- Reset, including mid-CLEAR:
  - FSM goes to IDLE; sweep counter, SCRATCH, RD_COUNT, WR_COUNT go to 0.
  - SRAM contents are undefined after reset.

## Timing
- Reset values: `gnt`=0, `rvalid`=0, `rdata`=0, all `sram_*` strobes 0, `sram_addr`/`sram_bm`/`sram_din`=0.
- Response latency:
  - `rvalid` is registered and pulses exactly 1 cycle after each grant, for reads and writes alike.
  - There is no back-pressure; responses are never dropped.
- `rdata` in the `rvalid` cycle:
  - SRAM read: `sram_dout`, muxed by a registered region select.
  - Register/unmapped read: registered value captured at grant.
  - Write: 0.
  - Outside `rvalid`: 0.
- Register update timing:
  - Register writes take effect the cycle after grant.
  - A read granted the cycle after a write to the same location returns the new value.
  - The same holds for SRAM read-after-write.
- CLEAR entry and exit:
  - The CTRL write is granted at cycle T; its `rvalid` is at T+1.
  - CLEAR occupies cycles T+1..T+DEPTH; `gnt` is low throughout.
  - The first grant is possible at T+DEPTH+1.
- CTRL write with `wdata[0]`=0, or with `be[0]`=0: no effect.
- Counter increments at the grant edge; RD_COUNT read in the following cycle shows the increment.

## Test plan
- Write 0xA5A5_1234 to 0x000010 with be=4'hF, read back with no idle cycle -> `rvalid` 1 cycle after each grant; rdata=0xA5A5_1234; WR_COUNT=1, RD_COUNT=1.
- Byte masking: write 0xFFFF_FFFF to 0x000020, then 0x0000_0000 with be=4'b0101, read -> 0xFF00_FF00; same sequence on SCRATCH (0x001004) -> 0xFF00_FF00.
- Clear sweep: fill words 0, 511, 1023 with nonzero data; write 1 to CTRL (0x001000), holding `req` high with a read of word 1023 -> `gnt` low exactly 1024 cycles; read then granted, returns 0.
- Unmapped: read 0x123400 -> 0xBADC0DE0 with `rvalid` 1 cycle after grant; write there -> `rvalid` pulse, no state change.
- Counters: 5 SRAM reads -> RD_COUNT=5; write any value to 0x001008 -> RD_COUNT=0 next cycle; WR_COUNT unchanged.
- Reset mid-CLEAR at sweep word 300 -> next cycle FSM in IDLE, `gnt` follows `req`, `rvalid`=0, SCRATCH=0, counters=0.

Source files
------------

// File: rtl/obi_sram_bridge.sv
// OBI-style bus target: SRAM window plus a small CSR bank.
// A CTRL write sweeps the SRAM with zeros while the bus is stalled.
module obi_sram_bridge #(
  parameter int unsigned DEPTH    = 1024,
  parameter logic [11:0] REG_BASE = 12'h001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [23:0] addr,
  input  logic [31:0] wdata,
  output logic        gnt,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic [9:0]  sram_addr,
  output logic [31:0] sram_bm,
  output logic [31:0] sram_din,
  output logic        sram_wen,
  output logic        sram_men,
  output logic        sram_ren,
  input  logic [31:0] sram_dout
);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  localparam logic [10:0] LAST = 11'(DEPTH - 1);
  localparam logic [31:0] UNMAPPED = 32'hBADC0DE0;

  state_t      state_q, state_d;
  logic [10:0] sweep_q, sweep_d;

  logic [31:0] scratch_q;
  logic [31:0] rdcnt_q;
  logic [31:0] wrcnt_q;

  logic        rvalid_q;
  logic        rsram_q;
  logic [31:0] rreg_q;

  logic        hit_sram;
  logic        hit_reg;
  logic [1:0]  ridx;
  logic [31:0] bmask;
  logic [31:0] reg_rd;
  logic        ctrl_go;
  logic        unused;

  assign hit_sram = (addr[23:12] == 12'h000);
  assign hit_reg  = (addr[23:12] == REG_BASE);
  assign ridx     = addr[3:2];
  assign unused   = ^addr[1:0];

  always_comb begin
    bmask = '0;
    for (int i = 0; i < 4; i++) begin
      bmask[8*i +: 8] = {8{be[i]}};
    end
  end

  // Requests are only ever accepted in IDLE and outside reset.
  assign gnt = req & ~rst & (state_q == S_IDLE);

  assign ctrl_go = gnt & hit_reg & we & (ridx == 2'd0)
                 & be[0] & wdata[0];

  always_comb begin
    reg_rd = UNMAPPED;
    if (hit_reg) begin
      unique case (1'b1)
        ridx == 2'd0: reg_rd = {31'b0, state_q == S_CLEAR};
        ridx == 2'd1: reg_rd = scratch_q;
        ridx == 2'd2: reg_rd = rdcnt_q;
        ridx == 2'd3: reg_rd = wrcnt_q;
        default:      reg_rd = UNMAPPED;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    sram_men  = 1'b0;
    sram_wen  = 1'b0;
    sram_ren  = 1'b0;
    sram_addr = '0;
    sram_bm   = '0;
    sram_din  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (gnt && hit_sram) begin
          sram_men  = 1'b1;
          sram_wen  = we;
          sram_ren  = ~we;
          sram_addr = addr[11:2];
          sram_bm   = bmask;
          sram_din  = wdata;
        end
        if (ctrl_go) begin
          state_d = S_CLEAR;
          sweep_d = '0;
        end
      end
      S_CLEAR: begin
        sram_men  = 1'b1;
        sram_wen  = 1'b1;
        sram_addr = sweep_q[9:0];
        sram_bm   = '1;
        sweep_d   = sweep_q + 11'd1;
        if (sweep_q == LAST) begin
          state_d = S_IDLE;
          sweep_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        sweep_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scratch_q <= '0;
      rdcnt_q   <= '0;
      wrcnt_q   <= '0;
    end else begin
      if (gnt && hit_sram) begin
        if (we) wrcnt_q <= wrcnt_q + 32'd1;
        else    rdcnt_q <= rdcnt_q + 32'd1;
      end
      if (gnt && hit_reg && we) begin
        unique case (1'b1)
          ridx == 2'd1:
            scratch_q <= (scratch_q & ~bmask) | (wdata & bmask);
          ridx == 2'd2: rdcnt_q <= '0;
          ridx == 2'd3: wrcnt_q <= '0;
          default: ;
        endcase
      end
    end
  end

  // Register/unmapped read data is frozen at grant; SRAM data comes later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rsram_q  <= 1'b0;
      rreg_q   <= '0;
    end else begin
      rvalid_q <= gnt;
      rsram_q  <= gnt & hit_sram & ~we;
      rreg_q   <= (gnt && !we && !hit_sram) ? reg_rd : 32'h0;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = !rvalid_q ? 32'h0
                : rsram_q   ? sram_dout
                :             rreg_q;

endmodule

// File: tb/tb_obi_sram_bridge.sv
// Bench for obi_sram_bridge: directed table, clear/reset sequences
// and random traffic against a transaction-level reference model.
module tb_obi_sram_bridge;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [23:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [9:0]  sram_addr;
  logic [31:0] sram_bm;
  logic [31:0] sram_din;
  logic        sram_wen;
  logic        sram_men;
  logic        sram_ren;
  logic [31:0] sram_dout;

  always #5 clk = ~clk;

  obi_sram_bridge #(.DEPTH(DEPTH), .REG_BASE(12'h001)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .be(be),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .sram_addr(sram_addr), .sram_bm(sram_bm),
    .sram_din(sram_din), .sram_wen(sram_wen),
    .sram_men(sram_men), .sram_ren(sram_ren),
    .sram_dout(sram_dout)
  );

  logic [31:0] smem [DEPTH];
  always @(posedge clk) begin
    if (sram_men && sram_wen)
      smem[sram_addr] <= (smem[sram_addr] & ~sram_bm)
                       | (sram_din & sram_bm);
    if (sram_men && sram_ren)
      sram_dout <= smem[sram_addr];
  end

  int total = 0;
  int bad = 0;

  logic [31:0] mem [DEPTH];
  bit          known [DEPTH];
  logic [31:0] scratch, rdc, wrc;
  int          clr_left;
  bit          pv, pknown, ptab;
  logic [31:0] pdata, ptabv;

  typedef struct {
    bit          w;
    logic [3:0]  b;
    logic [23:0] a;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;

  vec_t tab [28];

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o,
      input logic [31:0] n, input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (b[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] bmexp(input logic [3:0] b);
    return merge(32'h0, 32'hFFFFFFFF, b);
  endfunction

  function automatic int region(input logic [23:0] a);
    if (a[23:12] == 12'h000) return 0;
    if (a[23:12] == 12'h001) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    clr_left = 0;
    scratch = 0;
    rdc = 0;
    wrc = 0;
    pv = 0;
    ptab = 0;
    for (int i = 0; i < DEPTH; i++) known[i] = 0;
  endtask

  // One bus cycle: drive, check at negedge, advance the model.
  task automatic cycle(input bit r, input bit w, input logic [3:0] b,
      input logic [23:0] a, input logic [31:0] d, input bit tchk,
      input logic [31:0] texp, output bit g);
    bit eg;
    int wi;
    req = r; we = w; be = b; addr = a; wdata = d;
    @(negedge clk);
    eg = r && (clr_left == 0);
    wi = int'(a[11:2]);
    chk("gnt", gnt, eg);
    chk("rvalid", rvalid, pv);
    if (!pv) chk("rdata_idle", rdata, 0);
    else if (pknown) chk("rdata_model", rdata, pdata);
    if (pv && ptab) chk("rdata_table", rdata, ptabv);
    if (clr_left > 0)
      chk("sweep", {sram_men, sram_wen, sram_ren, sram_addr,
                    sram_bm, sram_din},
          {3'b110, 10'(DEPTH - clr_left), 32'hFFFFFFFF, 32'h0});
    else if (eg && region(a) == 0)
      chk("sram_port", {sram_men, sram_wen, sram_ren, sram_addr,
                        sram_bm, sram_din},
          {1'b1, w, !w, a[11:2], bmexp(b), d});
    else
      chk("sram_quiet", {sram_men, sram_wen, sram_ren, sram_addr,
                         sram_bm, sram_din}, 0);
    g = gnt;
    pv = eg;
    pknown = 1;
    pdata = 0;
    ptab = tchk && eg;
    ptabv = texp;
    if (clr_left > 0) clr_left--;
    else if (eg) begin
      if (!w) begin
        case (region(a))
          0: begin pdata = mem[wi]; pknown = known[wi]; rdc++; end
          1: case (a[3:2])
               2'd0: pdata = 0;
               2'd1: pdata = scratch;
               2'd2: pdata = rdc;
               default: pdata = wrc;
             endcase
          default: pdata = 32'hBADC0DE0;
        endcase
      end else begin
        case (region(a))
          0: begin
            mem[wi] = merge(mem[wi], d, b);
            if (b == 4'hF) known[wi] = 1;
            wrc++;
          end
          1: case (a[3:2])
               2'd0: if (b[0] && d[0]) begin
                 clr_left = DEPTH;
                 for (int i = 0; i < DEPTH; i++) begin
                   mem[i] = 0;
                   known[i] = 1;
                 end
               end
               2'd1: scratch = merge(scratch, d, b);
               2'd2: rdc = 0;
               default: wrc = 0;
             endcase
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req = 0; we = 0; be = 0; addr = 0; wdata = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_outs", {gnt, rvalid, rdata, sram_men, sram_wen,
                       sram_ren, sram_addr, sram_bm, sram_din}, 0);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic idle(input int n);
    bit g;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, g);
  endtask

  initial begin
    bit g;
    int n;
    logic [23:0] ra;
    logic [31:0] rd;
    bit rw;

    tab[0]  = '{1, 4'hF, 24'h000010, 32'hA5A51234, 32'h0};
    tab[1]  = '{0, 4'hF, 24'h000010, 32'h0, 32'hA5A51234};
    tab[2]  = '{0, 4'hF, 24'h00100C, 32'h0, 32'h1};
    tab[3]  = '{0, 4'hF, 24'h001008, 32'h0, 32'h1};
    tab[4]  = '{1, 4'hF, 24'h000020, 32'hFFFFFFFF, 32'h0};
    tab[5]  = '{1, 4'h5, 24'h000020, 32'h0, 32'h0};
    tab[6]  = '{0, 4'hF, 24'h000020, 32'h0, 32'hFF00FF00};
    tab[7]  = '{1, 4'hF, 24'h001004, 32'hFFFFFFFF, 32'h0};
    tab[8]  = '{1, 4'h5, 24'h001004, 32'h0, 32'h0};
    tab[9]  = '{0, 4'hF, 24'h001004, 32'h0, 32'hFF00FF00};
    tab[10] = '{0, 4'hF, 24'h123400, 32'h0, 32'hBADC0DE0};
    tab[11] = '{1, 4'hF, 24'h123400, 32'h1, 32'h0};
    tab[12] = '{0, 4'hF, 24'h001004, 32'h0, 32'hFF00FF00};
    tab[13] = '{0, 4'hF, 24'h001000, 32'h0, 32'h0};
    tab[14] = '{1, 4'hF, 24'h001000, 32'h0, 32'h0};
    tab[15] = '{1, 4'hE, 24'h001000, 32'h1, 32'h0};
    tab[16] = '{0, 4'hF, 24'h000020, 32'h0, 32'hFF00FF00};
    tab[17] = '{1, 4'hF, 24'h001008, 32'h77, 32'h0};
    tab[18] = '{0, 4'hF, 24'h001008, 32'h0, 32'h0};
    for (int i = 19; i < 24; i++)
      tab[i] = '{0, 4'hF, 24'h000010, 32'h0, 32'hA5A51234};
    tab[24] = '{0, 4'hF, 24'h001008, 32'h0, 32'h5};
    tab[25] = '{1, 4'hF, 24'h001008, 32'h0, 32'h0};
    tab[26] = '{0, 4'hF, 24'h001008, 32'h0, 32'h0};
    tab[27] = '{0, 4'hF, 24'h00100C, 32'h0, 32'h3};

    model_reset();
    do_reset();
    idle(2);

    for (int i = 0; i < 28; i++)
      cycle(1, tab[i].w, tab[i].b, tab[i].a, tab[i].d, 1,
            tab[i].e, g);
    idle(1);

    // Clear sweep with a read of word 1023 held pending.
    cycle(1, 1, 4'hF, 24'h000000, 32'h11111111, 0, 0, g);
    cycle(1, 1, 4'hF, 24'h0007FC, 32'h22222222, 0, 0, g);
    cycle(1, 1, 4'hF, 24'h000FFC, 32'h33333333, 0, 0, g);
    cycle(1, 0, 4'hF, 24'h000FFC, 32'h0, 1, 32'h33333333, g);
    cycle(1, 1, 4'h1, 24'h001000, 32'h1, 0, 0, g);
    n = 0;
    g = 0;
    while (!g && n < 2000) begin
      cycle(1, 0, 4'hF, 24'h000FFC, 32'h0, 1, 32'h0, g);
      if (!g) n++;
    end
    chk("clear_stall_cycles", n, DEPTH);
    cycle(1, 0, 4'hF, 24'h000000, 32'h0, 1, 32'h0, g);
    cycle(1, 0, 4'hF, 24'h0007FC, 32'h0, 1, 32'h0, g);
    idle(1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rw = 1'($urandom_range(0, 1));
      rd = $urandom;
      n = $urandom_range(0, 9);
      if (n < 6)
        ra = {12'h000, 6'h0, 4'($urandom_range(0, 15)), 2'b00};
      else if (n < 9) begin
        ra = {12'h001, 8'h0, 2'($urandom_range(0, 3)), 2'b00};
        if (ra[3:2] == 2'd0 && rw && $urandom_range(0, 29) != 0)
          rd[0] = 1'b0;
      end else
        ra = {12'h3AB, 12'($urandom)};
      cycle($urandom_range(0, 3) != 0, rw, 4'($urandom), ra, rd,
            0, 0, g);
    end
    while (clr_left > 0) idle(1);
    idle(1);

    // Reset in the middle of a sweep, at word 300.
    cycle(1, 1, 4'hF, 24'h001004, 32'h12345678, 0, 0, g);
    cycle(1, 0, 4'hF, 24'h000010, 32'h0, 0, 0, g);
    cycle(1, 1, 4'h1, 24'h001000, 32'h1, 0, 0, g);
    idle(300);
    do_reset();
    cycle(1, 0, 4'hF, 24'h001004, 32'h0, 1, 32'h0, g);
    cycle(1, 0, 4'hF, 24'h001008, 32'h0, 1, 32'h0, g);
    cycle(1, 0, 4'hF, 24'h00100C, 32'h0, 1, 32'h0, g);
    cycle(1, 0, 4'hF, 24'h001000, 32'h0, 1, 32'h0, g);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
